// File: rtl/bram_writer_in.sv
// Ping-pong BRAM frame writer: streams one frame into the current bank, then hands it to the reader.
// Optional macro ZERO_BORDER_EN forces the first border_cols columns of every row to zero.
module bram_writer_in #(
   parameter int width       = 120,
   parameter int height      = 240,
   parameter int frame_size  = width * height,
   parameter int addr_bits   = $clog2(frame_size),
   parameter int data_width  = 21,
   parameter int border_cols = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  wr_bram_index,
   output logic [addr_bits-1:0]  wr_address,
   output logic [data_width-1:0] wr_data,
   output logic                  wr_en,
   output logic                  rd_start,
   output logic                  rd_bram_index,
   input  logic                  rd_idle,
   output logic [15:0]           frame_count
);

   localparam int col_bits = (width > 1) ? $clog2(width) : 1;
   localparam logic [addr_bits-1:0] pix_last = addr_bits'(frame_size - 1);
   localparam logic [col_bits-1:0]  col_last = col_bits'(width - 1);
`ifdef ZERO_BORDER_EN
   localparam bit zero_border_on = 1'b1;
`else
   localparam bit zero_border_on = 1'b0;
`endif

   typedef enum logic {
      ST_RUNNING = 1'b0,
      ST_HANDOFF = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [addr_bits-1:0]  pix_q, pix_d;
   logic [col_bits-1:0]   col_q, col_d;
   logic                  wr_bram_index_q, wr_bram_index_d;
   logic                  wr_en_q, wr_en_d;
   logic [addr_bits-1:0]  wr_address_q, wr_address_d;
   logic [data_width-1:0] wr_data_q, wr_data_d;
   logic                  rd_start_q, rd_start_d;
   logic                  rd_bram_index_q, rd_bram_index_d;
   logic [15:0]           frame_count_q, frame_count_d;
   logic                  xfer;
   logic                  zero_px;

   assign in_ready = (state_q == ST_RUNNING);
   assign xfer     = in_valid && in_ready;
   assign zero_px  = zero_border_on && (int'(col_q) < border_cols);

   always_comb begin
      state_d         = state_q;
      pix_d           = pix_q;
      col_d           = col_q;
      wr_bram_index_d = wr_bram_index_q;
      wr_en_d         = 1'b0;
      wr_address_d    = wr_address_q;
      wr_data_d       = wr_data_q;
      rd_start_d      = 1'b0;
      rd_bram_index_d = rd_bram_index_q;
      frame_count_d   = frame_count_q;

      case (state_q)
         ST_RUNNING: begin
            if (xfer) begin
               wr_en_d      = 1'b1;
               wr_address_d = pix_q;
               wr_data_d    = zero_px ? '0 : in_data;
               if (pix_q == pix_last) begin
                  pix_d   = '0;
                  col_d   = '0;
                  state_d = ST_HANDOFF;
               end else begin
                  pix_d = pix_q + 1'b1;
                  col_d = (col_q == col_last) ? '0 : col_q + 1'b1;
               end
            end
         end
         ST_HANDOFF: begin
            // The final write is issued in this state's first cycle, so any
            // hand-off is at least one cycle after the last transfer.
            if (rd_idle) begin
               rd_start_d      = 1'b1;
               rd_bram_index_d = wr_bram_index_q;
               wr_bram_index_d = ~wr_bram_index_q;
               frame_count_d   = frame_count_q + 16'd1;
               state_d         = ST_RUNNING;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_RUNNING;
         pix_q           <= '0;
         col_q           <= '0;
         wr_bram_index_q <= 1'b0;
         wr_en_q         <= 1'b0;
         wr_address_q    <= '0;
         wr_data_q       <= '0;
         rd_start_q      <= 1'b0;
         rd_bram_index_q <= 1'b0;
         frame_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         pix_q           <= pix_d;
         col_q           <= col_d;
         wr_bram_index_q <= wr_bram_index_d;
         wr_en_q         <= wr_en_d;
         wr_address_q    <= wr_address_d;
         wr_data_q       <= wr_data_d;
         rd_start_q      <= rd_start_d;
         rd_bram_index_q <= rd_bram_index_d;
         frame_count_q   <= frame_count_d;
      end
   end

   assign wr_bram_index = wr_bram_index_q;
   assign wr_en         = wr_en_q;
   assign wr_address    = wr_address_q;
   assign wr_data       = wr_data_q;
   assign rd_start      = rd_start_q;
   assign rd_bram_index = rd_bram_index_q;
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_bram_writer_in.sv
// Randomized self-checking bench for bram_writer_in (4x2 frame) against a frame-level reference model.
module tb_bram_writer_in;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int FS = W * H;
   localparam int AB = 3;
   localparam int DW = 21;
   localparam int BC = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          wr_bram_index;
   logic [AB-1:0] wr_address;
   logic [DW-1:0] wr_data;
   logic          wr_en;
   logic          rd_start;
   logic          rd_bram_index;
   logic          rd_idle = 1'b1;
   logic [15:0]   frame_count;

   bram_writer_in #(
      .width(W), .height(H), .frame_size(FS), .addr_bits(AB),
      .data_width(DW), .border_cols(BC)
   ) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .wr_bram_index(wr_bram_index), .wr_address(wr_address),
      .wr_data(wr_data), .wr_en(wr_en), .rd_start(rd_start),
      .rd_bram_index(rd_bram_index), .rd_idle(rd_idle), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: frame position, bank in use, hand-off pending
   int            m_pix;
   bit            m_bank;
   bit            m_rd_bank;
   bit            m_busy;
   logic [15:0]   m_frames;

   int            last_xfer = -100;
   int            last_start = -100;
   bit            start_banks[$];
   logic [DW-1:0] cap_data[FS];
   int            last_wr_addr;
   bit            seen_ready;
   int            low_cnt;
   int            wr_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] exp_pixel(input int idx, input logic [DW-1:0] d);
`ifdef ZERO_BORDER_EN
      if ((idx % W) < BC) return '0;
`endif
      return d;
   endfunction

   // One clock: drive at the falling edge, predict, then sample at the next falling edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic idle, input logic rst);
      bit            e_wr_en;
      bit            e_rd_start;
      int            e_addr;
      logic [DW-1:0] e_data;
      bit            xfer;
      bit            hand;
      reset    = rst;
      in_valid = v;
      in_data  = d;
      rd_idle  = idle;
      #1;
      seen_ready = in_ready;
      if (!rst) check_eq("in_ready", 32'(in_ready), 32'(!m_busy));
      e_wr_en = 1'b0; e_rd_start = 1'b0; e_addr = 0; e_data = '0;
      if (rst) begin
         m_pix = 0; m_bank = 1'b0; m_rd_bank = 1'b0; m_busy = 1'b0; m_frames = '0;
         start_banks.delete();
      end else begin
         xfer = v && !m_busy;
         hand = m_busy && idle;
         if (xfer) begin
            e_wr_en = 1'b1;
            e_addr  = m_pix;
            e_data  = exp_pixel(m_pix, d);
            last_xfer = cyc;
            if (m_pix == FS - 1) begin
               m_pix  = 0;
               m_busy = 1'b1;
            end else begin
               m_pix++;
            end
         end
         if (hand) begin
            e_rd_start = 1'b1;
            m_rd_bank  = m_bank;
            m_bank     = ~m_bank;
            m_frames   = m_frames + 16'd1;
            m_busy     = 1'b0;
         end
      end
      @(negedge clk);
      cyc++;
      check_eq("wr_en", 32'(wr_en), 32'(e_wr_en));
      if (e_wr_en || rst) begin
         check_eq("wr_address", 32'(wr_address), 32'(e_addr));
         check_eq("wr_data", 32'(wr_data), 32'(e_data));
      end
      check_eq("rd_start", 32'(rd_start), 32'(e_rd_start));
      check_eq("rd_bram_index", 32'(rd_bram_index), 32'(m_rd_bank));
      check_eq("wr_bram_index", 32'(wr_bram_index), 32'(m_bank));
      check_eq("frame_count", 32'(frame_count), 32'(m_frames));
      if (wr_en) begin
         cap_data[wr_address] = wr_data;
         last_wr_addr = int'(wr_address);
      end
      if (rd_start) begin
         last_start = cyc;
         start_banks.push_back(rd_bram_index);
      end
   endtask

   initial begin
      logic [DW-1:0] exp1[FS];
      int rise_cyc;
`ifdef ZERO_BORDER_EN
      exp1 = '{21'd0, 21'd2, 21'd3, 21'd4, 21'd0, 21'd6, 21'd7, 21'd8};
`else
      exp1 = '{21'd1, 21'd2, 21'd3, 21'd4, 21'd5, 21'd6, 21'd7, 21'd8};
`endif
      @(negedge clk);

      // Continuous frame, reader always idle
      step(1'b0, '0, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      for (int i = 1; i <= FS; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      check_eq("t1_latency", 32'(last_start - last_xfer), 32'd2);
      for (int a = 0; a < FS; a++) check_eq("t1_data", 32'(cap_data[a]), 32'(exp1[a]));
      check_eq("t1_starts", 32'(start_banks.size()), 32'd1);
      if (start_banks.size() > 0) check_eq("t1_bank", 32'(start_banks[0]), 32'd0);
      check_eq("t1_wr_bank", 32'(wr_bram_index), 32'd1);
      check_eq("t1_fcount", 32'(frame_count), 32'd1);

      // Reader busy for 20 cycles at frame end
      step(1'b0, '0, 1'b1, 1'b1);
      for (int i = 1; i <= FS; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
      low_cnt = 0; wr_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, DW'(9), 1'b0, 1'b0);
         if (!seen_ready) low_cnt++;
         if (wr_en) wr_cnt++;
      end
      check_eq("t2_stall", 32'(low_cnt), 32'd20);
      check_eq("t2_no_write", 32'(wr_cnt), 32'd0);
      check_eq("t2_no_start", 32'(start_banks.size()), 32'd0);
      rise_cyc = cyc;
      step(1'b1, DW'(9), 1'b1, 1'b0);
      check_eq("t2_start_lat", 32'(last_start - rise_cyc), 32'd1);
      step(1'b1, DW'(9), 1'b1, 1'b0);
      check_eq("t2_px9_en", 32'(wr_en), 32'd1);
      check_eq("t2_px9_bank", 32'(wr_bram_index), 32'd1);
      check_eq("t2_px9_addr", 32'(wr_address), 32'd0);
      check_eq("t2_px9_data", 32'(wr_data), 32'(exp_pixel(0, DW'(9))));

      // Random valid gaps and reader stalls over three frames
      step(1'b0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 400 && m_frames < 16'd3; k++)
         step(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      check_eq("t3_fcount", 32'(frame_count), 32'd3);
      check_eq("t3_starts", 32'(start_banks.size()), 32'd3);
      for (int i = 0; i < start_banks.size(); i++)
         check_eq("t3_bank_alt", 32'(start_banks[i]), 32'(i % 2));

      // Reset in the middle of a frame
      step(1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, DW'(20 + i), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      check_eq("t4_wr_en", 32'(wr_en), 32'd0);
      check_eq("t4_fcount", 32'(frame_count), 32'd0);
      check_eq("t4_bank", 32'(wr_bram_index), 32'd0);
      step(1'b1, DW'(77), 1'b1, 1'b0);
      check_eq("t4_addr", 32'(last_wr_addr), 32'd0);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
      check_eq("t4_no_start", 32'(start_banks.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/bram_writer_in.md
Name: bram_writer_in

Overview:
- Upstream neighbour of the disparity BRAM output reader.
- Accepts a valid/ready pixel stream and writes one frame of frame_size words into one bank of a ping-pong BRAM pair.
- At frame end, hands the filled bank to the reader with a start pulse and bank index, then switches to the other bank.
- Stalls the input (in_ready low) whenever the reader is still busy, so no frame data is ever overwritten while being read.

Parameters:
- width, 120, pixels per row
- height, 240, rows per frame
- frame_size, width*height, words per frame
- addr_bits, $clog2(frame_size), BRAM address width
- data_width, 21, pixel word width
- border_cols, 16, leading columns forced to zero (used only with ZERO_BORDER_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_data  in  data_width  input pixel
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- wr_bram_index  out  1  bank being written
- wr_address  out  addr_bits  BRAM write address
- wr_data  out  data_width  BRAM write data
- wr_en  out  1  BRAM write strobe
- rd_start  out  1  one-cycle pulse: frame ready for reader
- rd_bram_index  out  1  bank handed to reader; valid in the rd_start cycle and held afterwards
- rd_idle  in  1  reader idle status
- frame_count  out  16  frames handed off; wraps from 0xFFFF to 0

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset is synchronous and active-high.
- Reset values (reset mid-frame discards the partial frame; no rd_start is issued for it):
  - state = ST_RUNNING
  - pixel counter = 0; column counter = 0
  - wr_bram_index = 0
  - wr_en = 0; wr_address = 0; wr_data = 0
  - rd_start = 0; rd_bram_index = 0
  - frame_count = 0
- States:
  - ST_RUNNING: in_ready = 1.
  - ST_HANDOFF: in_ready = 0.
  - in_ready is combinational from state only; it never depends on in_valid.
- Transfer: in_valid && in_ready. On each transfer, the next cycle has:
  - wr_en = 1
  - wr_address = pixel counter value at the transfer
  - wr_data = in_data
  - Write latency is exactly 1 cycle. wr_en = 0 in every cycle not following a transfer.
- Counters, per transfer:
  - Pixel counter increments.
  - Column counter increments, wrapping from width-1 to 0.
- Frame end:
  - On the transfer with pixel counter == frame_size-1: pixel counter <= 0, column counter <= 0, state <= ST_HANDOFF.
  - The final write (wr_en) occurs in the first ST_HANDOFF cycle.
- ST_HANDOFF:
  - Waits at least one full cycle, so the final write has committed.
  - Then, in the first cycle with rd_idle = 1, the next cycle has:
    - rd_start = 1 for one cycle
    - rd_bram_index = bank just filled
    - wr_bram_index toggled
    - frame_count incremented
    - state = ST_RUNNING
  - Earliest rd_start is 2 cycles after the last transfer.
- rd_idle low throughout ST_HANDOFF: in_ready stays low indefinitely; no data is lost and the upstream holds.
- Illegal to assume: rd_idle is not re-checked in ST_RUNNING. The single-pulse handshake plus the ST_HANDOFF wait guarantees the reader finished bank B before the writer hands off bank A again.
- in_valid while in_ready = 0: ignored; no write occurs and counters hold.
- Width rule: pixel counter is addr_bits wide; compare for equality only, so no overflow is possible.

Optional Feature:
- Macro: ZERO_BORDER_EN
- Defined: pixels whose column counter < border_cols are written with wr_data = 0 (address and handshake unchanged). Masks invalid left-edge disparities.
- Undefined: wr_data = in_data always; border_cols is unused.

Test Plan:
- width=4, height=2, rd_idle=1; stream values 1..8 continuously:
  - wr_en high 8 cycles, addresses 0..7, data 1..8, wr_bram_index=0.
  - rd_start pulse 2 cycles after the 8th transfer with rd_bram_index=0.
  - Then wr_bram_index=1, frame_count=1.
- Same setup, rd_idle=0 at frame end for 20 cycles:
  - in_ready low 20+ cycles, no wr_en, no rd_start.
  - rd_start 1 cycle after rd_idle rises.
  - Subsequent 9th pixel written to bank 1, address 0.
- Random in_valid gaps (50% duty) over 3 frames:
  - Addresses contiguous 0..7 per frame with no duplicates or skips.
  - Banks alternate 0,1,0; frame_count=3.
- Assert reset after 5 transfers:
  - Next cycle wr_en=0, frame_count=0, wr_bram_index=0.
  - Next transfer written at address 0; no rd_start for the aborted frame.
- ZERO_BORDER_EN with border_cols=1, width=4, stream 1..8:
  - Written data 0,2,3,4,0,6,7,8.
  - Without the macro, written data is 1..8.
